// File: rtl/nco_wave_sequencer.sv
//------------------------------------------------------------------------------
// nco_wave_sequencer
//
// Queues waveform-select requests and hands them to an NCO one period at a
// time. Requests land in a small FIFO. A two-state FSM (IDLE / RUN) pops the
// head into signal_out when leaving IDLE, and again at each period boundary.
// So the select seen by the NCO only ever changes on a whole-period edge. If
// the queue runs dry, the current waveform simply repeats. A stop pulse is
// remembered and honoured at the next boundary. Stop wins over a pending pop,
// and queued entries are kept.
//
// Configuration macros:
//   SELECT_WIDTH      default for SEL_W when the parameter is not overridden
//   NCO_SEQ_DWELL_EN  adds req_dwell[3:0]; each entry then holds its select
//                     for (req_dwell+1) periods before the next boundary
//
// Parameters:
//   SEL_W       width of the waveform-select code
//   FIFO_DEPTH  queued requests (power of two, >= 2)
//   PERIOD      cycles per NCO period (power of two)
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-high reset
//   req_valid     a select request is offered
//   req_sel       requested select code
//   req_dwell     extra periods to hold the select (NCO_SEQ_DWELL_EN only)
//   req_ready     FIFO not full (registered count only, no bypass)
//   stop          single-cycle pulse asking for a return to IDLE
//   signal_out    registered select driven to the NCO
//   nco_en        registered NCO enable
//   phase_cnt     registered position within the current period
//   switch_pulse  one-cycle flag after signal_out is loaded from the FIFO
//   busy          FSM not idle, or requests still queued
//------------------------------------------------------------------------------

`ifndef SELECT_WIDTH
`define SELECT_WIDTH 4
`endif

module nco_wave_sequencer #(
  parameter int SEL_W      = `SELECT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [SEL_W-1:0]          req_sel,
`ifdef NCO_SEQ_DWELL_EN
  input  logic [3:0]                req_dwell,
`endif
  output logic                      req_ready,
  input  logic                      stop,
  output logic [SEL_W-1:0]          signal_out,
  output logic                      nco_en,
  output logic [$clog2(PERIOD)-1:0] phase_cnt,
  output logic                      switch_pulse,
  output logic                      busy
);

  localparam int PH_W  = $clog2(PERIOD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef NCO_SEQ_DWELL_EN
  localparam int ENTRY_W = SEL_W + 4;
`else
  localparam int ENTRY_W = SEL_W;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               stop_pending;
  logic [3:0]         hold_cnt;

  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               at_wrap;
  logic               boundary;
  logic               stop_now;
  logic               go_idle;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [SEL_W-1:0]   head_sel;

  // Queue status comes straight from the registered count. A request pushed
  // this edge can therefore never be popped on the same edge.
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready;

  // A boundary is the last cycle of a period once any extra dwell periods have
  // been used up. A stop seen on the boundary edge itself counts as pending.
  assign at_wrap  = (state == RUN) && (phase_cnt == PH_W'(PERIOD - 1));
  assign boundary = at_wrap && (hold_cnt == 4'd0);
  assign stop_now = stop_pending || stop;
  assign go_idle  = boundary && stop_now;

  // Leaving IDLE always takes the head. In RUN, a pop needs a boundary with
  // no stop pending, because stop has priority and leaves the queue intact.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (boundary && !stop_now));

  assign head_entry = fifo_mem[rd_ptr];
  assign head_sel   = head_entry[SEL_W-1:0];

`ifdef NCO_SEQ_DWELL_EN
  assign push_entry = {req_dwell, req_sel};
`else
  assign push_entry = req_sel;
`endif

  assign busy = (state != IDLE) || !fifo_empty;

  // FIFO storage has no reset. Stale data is harmless because the pointers
  // and count are cleared, so nothing unwritten is ever read as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because the
  // depth is a power of two. A simultaneous push and pop leaves the count
  // unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sequencer FSM with registered NCO-facing outputs.
  // In IDLE, the outputs sit at zero. Any queued request starts a run on the
  // next edge. A stop arriving in IDLE only lives for one cycle in the flag.
  // In RUN, the phase free-runs and wraps. Boundaries either return to IDLE
  // (stop pending), load the next select (queue non-empty), or keep the
  // current select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      signal_out   <= '0;
      nco_en       <= 1'b0;
      phase_cnt    <= '0;
      switch_pulse <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      case (state)
        IDLE: begin
          signal_out <= '0;
          nco_en     <= 1'b0;
          phase_cnt  <= '0;
          if (!fifo_empty) begin
            state        <= RUN;
            signal_out   <= head_sel;
            nco_en       <= 1'b1;
            switch_pulse <= 1'b1;
            stop_pending <= 1'b0;
          end else begin
            stop_pending <= stop;
          end
        end
        RUN: begin
          phase_cnt <= phase_cnt + PH_W'(1);
          if (go_idle) begin
            state        <= IDLE;
            signal_out   <= '0;
            nco_en       <= 1'b0;
            phase_cnt    <= '0;
            stop_pending <= 1'b0;
          end else begin
            stop_pending <= stop_now;
            if (pop) begin
              signal_out   <= head_sel;
              switch_pulse <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NCO_SEQ_DWELL_EN
  // Dwell counter. Each popped entry loads its own dwell value. Every period
  // wrap while the counter is non-zero uses up one extra period. Boundaries
  // are suppressed until the counter reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 4'd0;
    end else if (pop) begin
      hold_cnt <= head_entry[SEL_W+3:SEL_W];
    end else if (go_idle) begin
      hold_cnt <= 4'd0;
    end else if (at_wrap && (hold_cnt != 4'd0)) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end
`else
  // Without dwell support, every period wrap is a boundary.
  assign hold_cnt = 4'd0;
`endif

endmodule
